// File: rtl/ft_pkg.sv
// Shared fault-tolerance types: recovery FSM state encoding and default widths.
// Latency: n/a (types only). Backpressure: n/a.
// Reused by the recovery controller and the replay engine.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_COPY    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } ft_state_e;

    localparam int FT_ADDR_WIDTH = 5;
    localparam int FT_DATA_WIDTH = 32;

endpackage

// File: rtl/replay_seq_check.sv
// Replay sequence checker: accepts only the next expected register index, flags others.
// Latency: accept/error/last combinational; expected index advances on the accepting edge.
// Backpressure: none; mismatched indices are dropped, not stalled.
module replay_seq_check
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = FT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  accept_o,
    output logic                  error_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] exp_q;
    logic                  hit;

    assign hit      = en_i && valid_i;
    assign accept_o = hit && (addr_i == exp_q);
    assign error_o  = hit && (addr_i != exp_q);
    assign last_o   = accept_o && (&addr_i);

    // Holds at the top index after the final accept instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            exp_q <= '0;
        end else if (accept_o && !last_o) begin
            exp_q <= exp_q + 1'b1;
        end
    end

endmodule

// File: rtl/recovery_replay.sv
// Copies the healthy core's PC and register file into the target core after a halt.
// Latency: read issued same cycle as accept, write one cycle later; optional macro RECOVERY_REPLAY_X0_SKIP_EN.
// Backpressure: none; out-of-sequence indices are dropped and flagged on sticky seq_err_o.
module recovery_replay
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  halt_i,
    input  logic                  shift_i,
    input  logic                  replay_valid_i,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    input  logic                  resume_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  src_re_o,
    output logic [ADDR_WIDTH-1:0] src_raddr_o,
    input  logic [DATA_WIDTH-1:0] src_rdata_i,
    output logic                  dst_we_o,
    output logic [ADDR_WIDTH-1:0] dst_waddr_o,
    output logic [DATA_WIDTH-1:0] dst_wdata_o,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  seq_err_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    ft_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  seq_err_q, seq_err_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rel_first_q;
    logic                  chk_clear, chk_acc, chk_err, chk_last;
    logic                  skip_x0;

`ifdef RECOVERY_REPLAY_X0_SKIP_EN
    assign skip_x0 = (replay_addr_i == '0);
`else
    assign skip_x0 = 1'b0;
`endif

    replay_seq_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq_check (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (chk_clear),
        .en_i     (state_q == ST_COPY),
        .valid_i  (replay_valid_i),
        .addr_i   (replay_addr_i),
        .accept_o (chk_acc),
        .error_o  (chk_err),
        .last_o   (chk_last)
    );

    assign count_o   = count_q;
    assign seq_err_o = seq_err_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        seq_err_d   = seq_err_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        chk_clear   = 1'b0;
        src_re_o    = 1'b0;
        src_raddr_o = '0;
        dst_we_o    = 1'b0;
        dst_waddr_o = '0;
        dst_wdata_o = '0;
        pc_we_o     = 1'b0;
        pc_o        = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        // Write-back of the read issued in the previous cycle.
        if (wr_pend_q) begin
            dst_we_o    = 1'b1;
            dst_waddr_o = wr_addr_q;
            dst_wdata_o = src_rdata_i;
            count_d     = count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (halt_i) begin
                    state_d   = ST_CAPTURE;
                    count_d   = '0;
                    seq_err_d = 1'b0;
                    chk_clear = 1'b1;
                end
            end
            ST_CAPTURE: begin
                busy_o = 1'b1;
                pc_o   = pc_q;
                if (shift_i) begin
                    pc_d    = pc_i;
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                busy_o = 1'b1;
                pc_o   = pc_q;
                if (chk_err) begin
                    seq_err_d = 1'b1;
                end
                if (chk_acc && !skip_x0) begin
                    src_re_o    = 1'b1;
                    src_raddr_o = replay_addr_i;
                    wr_pend_d   = 1'b1;
                    wr_addr_d   = replay_addr_i;
                end
                if (chk_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o  = 1'b1;
                pc_o    = pc_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                done_o  = 1'b1;
                pc_o    = pc_q;
                pc_we_o = rel_first_q;
                if (resume_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            count_q     <= '0;
            seq_err_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            rel_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            seq_err_q   <= seq_err_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            rel_first_q <= (state_q == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_recovery_replay.sv
// Directed bench for recovery_replay: normal, gapped, out-of-order, mid-copy reset, spurious controls.
module tb_recovery_replay;

`ifdef RECOVERY_REPLAY_X0_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [5:0] FULL_CNT = SKIP ? 6'd31 : 6'd32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        halt_i = 1'b0;
    logic        shift_i = 1'b0;
    logic        replay_valid_i = 1'b0;
    logic [4:0]  replay_addr_i = '0;
    logic        resume_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        src_re_o;
    logic [4:0]  src_raddr_o;
    logic [31:0] src_rdata_i = '0;
    logic        dst_we_o;
    logic [4:0]  dst_waddr_o;
    logic [31:0] dst_wdata_o;
    logic        pc_we_o;
    logic [31:0] pc_o;
    logic        busy_o;
    logic        done_o;
    logic        seq_err_o;
    logic [5:0]  count_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    recovery_replay #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .halt_i         (halt_i),
        .shift_i        (shift_i),
        .replay_valid_i (replay_valid_i),
        .replay_addr_i  (replay_addr_i),
        .resume_i       (resume_i),
        .pc_i           (pc_i),
        .src_re_o       (src_re_o),
        .src_raddr_o    (src_raddr_o),
        .src_rdata_i    (src_rdata_i),
        .dst_we_o       (dst_we_o),
        .dst_waddr_o    (dst_waddr_o),
        .dst_wdata_o    (dst_wdata_o),
        .pc_we_o        (pc_we_o),
        .pc_o           (pc_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .seq_err_o      (seq_err_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one replay cycle; outputs are checked 1 time unit later.
    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] rd);
        replay_valid_i = v;
        replay_addr_i  = a;
        src_rdata_i    = rd;
        #1;
    endtask

    task automatic enter_copy(input logic [31:0] pc);
        halt_i = 1'b1;
        tick();
        halt_i  = 1'b0;
        shift_i = 1'b1;
        pc_i    = pc;
        tick();
        shift_i = 1'b0;
        pc_i    = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic we_exp;

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_err", seq_err_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_we", dst_we_o, 0);

        // Normal back-to-back replay
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        #1;
        chk("cap_busy", busy_o, 1);
        tick();                       // no shift: stays in CAPTURE
        chk("cap_hold", busy_o, 1);
        shift_i = 1'b1;
        pc_i    = 32'h0000_0480;
        tick();
        shift_i = 1'b0;
        pc_i    = 32'h0;
        chk("copy_pc", pc_o, 32'h480);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), (a > 0) ? 32'((a - 1) * 4) : 32'hDEAD_BEEF);
            chk("n_re", src_re_o, !(SKIP && a == 0));
            chk("n_raddr", src_raddr_o, (SKIP && a == 0) ? 0 : a);
            we_exp = (a > 0) && !(SKIP && a == 1);
            chk("n_we", dst_we_o, we_exp);
            if (we_exp) begin
                chk("n_waddr", dst_waddr_o, a - 1);
                chk("n_wdata", dst_wdata_o, (a - 1) * 4);
            end
            if (a == 6) chk("n_wdata_r5", dst_wdata_o, 32'h14);
            tick();
        end
        drive(1'b0, 5'd0, 32'h7C);
        chk("drain_busy", busy_o, 1);
        chk("drain_we", dst_we_o, 1);
        chk("drain_waddr", dst_waddr_o, 31);
        chk("drain_wdata", dst_wdata_o, 32'h7C);
        tick();
        chk("rel_pcwe", pc_we_o, 1);
        chk("rel_pc", pc_o, 32'h480);
        chk("rel_done", done_o, 1);
        chk("rel_busy", busy_o, 0);
        chk("rel_count", count_o, FULL_CNT);
        chk("rel_err", seq_err_o, 0);

        // Spurious halt in RELEASE, then resume
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        chk("rel2_pcwe", pc_we_o, 0);
        chk("rel2_done", done_o, 1);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        chk("idle_done", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_count", count_o, FULL_CNT);
        chk("idle_pc", pc_o, 0);

        // Gapped replay
        enter_copy(32'h0000_1234);
        chk("g_cnt_clr", count_o, 0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 32'hDEAD_BEEF);
            chk("g_we_on_valid", dst_we_o, 0);
            tick();
            drive(1'b0, 5'((a + 7) % 32), 32'(a * 4));
            we_exp = !(SKIP && a == 0);
            chk("g_we", dst_we_o, we_exp);
            if (we_exp) chk("g_wdata", dst_wdata_o, a * 4);
            if (a == 31) chk("g_drain_busy", busy_o, 1);
            tick();
        end
        chk("g_done", done_o, 1);
        chk("g_err", seq_err_o, 0);
        chk("g_count", count_o, FULL_CNT);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;

        // Out-of-order: 0,1,3 then 2..31
        enter_copy(32'h0000_0480);
        drive(1'b1, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd1, 32'h0);
        tick();
        drive(1'b1, 5'd3, 32'h4);
        chk("ooo_re3", src_re_o, 0);
        chk("ooo_err_pre", seq_err_o, 0);
        tick();
        resume_i = 1'b1;              // ignored outside RELEASE
        drive(1'b0, 5'd0, 32'hC);
        chk("ooo_err", seq_err_o, 1);
        chk("ooo_drop3", dst_we_o, 0);
        tick();
        resume_i = 1'b0;
        chk("ooo_resume_ign", busy_o, 1);
        for (int a = 2; a < 32; a++) begin
            drive(1'b1, 5'(a), (a > 2) ? 32'((a - 1) * 4) : 32'h0);
            chk("ooo_re", src_re_o, 1);
            tick();
        end
        drive(1'b0, 5'd0, 32'h7C);
        tick();
        chk("ooo_count", count_o, FULL_CNT);
        chk("ooo_err_hold", seq_err_o, 1);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        chk("ooo_err_idle", seq_err_o, 1);
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        chk("ooo_err_clr", seq_err_o, 0);

        // Reset on the addr-10 accept
        shift_i = 1'b1;
        pc_i    = 32'h0000_0480;
        tick();
        shift_i = 1'b0;
        for (int a = 0; a < 10; a++) begin
            drive(1'b1, 5'(a), 32'h0);
            tick();
        end
        drive(1'b1, 5'd10, 32'h24);
        rst_i = 1'b1;
        chk("r_re10", src_re_o, 1);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 32'h28);
        chk("r_we", dst_we_o, 0);
        chk("r_busy", busy_o, 0);
        chk("r_count", count_o, 0);
        chk("r_pc", pc_o, 0);
        chk("r_done", done_o, 0);
        chk("r_pcwe", pc_we_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/recovery_replay.md
RECOVERY_REPLAY -- requirements
Module: recovery_replay

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width; NUM_REG = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register and PC data width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port halt_i  input  1  recovery request from the recovery controller.
REQ-006 SHALL have port shift_i  input  1  PC capture strobe from the controller.
REQ-007 SHALL have port replay_valid_i  input  1  replay_addr_i is valid this cycle.
REQ-008 SHALL have port replay_addr_i  input  ADDR_WIDTH  register index to copy.
REQ-009 SHALL have port resume_i  input  1  controller releases the cores.
REQ-010 SHALL have port pc_i  input  DATA_WIDTH  PC of the healthy (source) core.
REQ-011 SHALL have port src_re_o  output  1, and src_raddr_o  output  ADDR_WIDTH: source regfile read port.
REQ-012 SHALL have port src_rdata_i  input  DATA_WIDTH  source read data, valid exactly one cycle after src_re_o.
REQ-013 SHALL have ports dst_we_o  output  1, dst_waddr_o  output  ADDR_WIDTH, dst_wdata_o  output  DATA_WIDTH: target regfile write port.
REQ-014 SHALL have ports pc_we_o  output  1 and pc_o  output  DATA_WIDTH: target PC write.
REQ-015 SHALL have outputs busy_o (1), done_o (1), seq_err_o (1, sticky), count_o (ADDR_WIDTH+1, registers written).

Function
REQ-016 SHALL implement states IDLE, CAPTURE, COPY, DRAIN, RELEASE.
REQ-017 IDLE: all outputs 0 except count_o/seq_err_o hold; halt_i=1 -> CAPTURE next cycle, clearing count_o, seq_err_o and expected-address counter (exp).
REQ-018 CAPTURE: busy_o=1; on shift_i=1 latch pc_i into pc_o register and go to COPY; otherwise stay.
REQ-019 COPY: when replay_valid_i=1 and replay_addr_i==exp, src_re_o=1 and src_raddr_o=replay_addr_i combinationally in the same cycle; address registered; exp increments.
REQ-020 Write-back: one cycle after an accepted read, dst_we_o=1, dst_waddr_o=registered address, dst_wdata_o=src_rdata_i; count_o increments that cycle; back-to-back accepts give one write per cycle, pipelined.
REQ-021 Mismatch (replay_valid_i=1, replay_addr_i!=exp): no read, no write, exp unchanged, seq_err_o set and held until next IDLE->CAPTURE.
REQ-022 Accept of address NUM_REG-1 -> DRAIN; exp does not wrap.
REQ-023 DRAIN: completes the final pending write (one cycle) -> RELEASE.
REQ-024 RELEASE: pc_we_o=1 for exactly the first RELEASE cycle; done_o=1 throughout; busy_o=0; resume_i=1 -> IDLE.
REQ-025 halt_i outside IDLE, shift_i outside CAPTURE, replay_valid_i outside COPY, resume_i outside RELEASE SHALL be ignored.
REQ-026 busy_o SHALL be 1 in CAPTURE, COPY, DRAIN.

Reset
REQ-027 rst_i=1 SHALL force IDLE, clear pc_o, exp, count_o, seq_err_o and the pending-write register next edge; all strobes 0.
REQ-028 Reset mid-COPY SHALL drop any pending write (no dst_we_o in the following cycle).

Configuration
REQ-029 With macro RECOVERY_REPLAY_X0_SKIP_EN defined, an accepted address 0 SHALL advance exp but issue no read and no write and not increment count_o (final count_o = NUM_REG-1).
REQ-030 Without RECOVERY_REPLAY_X0_SKIP_EN, address 0 SHALL be copied like any other (final count_o = NUM_REG).

Structure
REQ-031 State enum (3-bit) and default widths SHALL live in shared package ft_pkg, reusable by the recovery controller.
REQ-032 The expected-address/sequence checker SHALL be sub-module replay_seq_check (inputs valid/addr, outputs accept/error/last).

Verification
REQ-033 Normal: reset, halt_i=1, shift_i with pc_i=0x0000_0480, addresses 0..31 one per cycle, src_rdata=addr*4 -> 32 writes, dst_wdata_o for addr 5 = 0x14, pc_we_o once with 0x480, done_o, count_o=32.
REQ-034 Gapped replay: valid low every other cycle -> same 32 writes, no seq_err_o, DRAIN one cycle after addr 31 write-accept.
REQ-035 Out-of-order: send 0,1,3 -> addr 3 dropped, seq_err_o=1, exp stays 2; then 2..31 completes with count_o=32.
REQ-036 Reset at addr 10 accept -> no write next cycle, IDLE, count_o=0, outputs zero.
REQ-037 X0 skip build: full sequence -> no write to address 0, count_o=31.
REQ-038 Spurious: resume_i during COPY and halt_i during RELEASE -> ignored; resume_i in RELEASE returns to IDLE.
